// File: rtl/alu_pkg.sv
// Shared definitions for the two-register ALU datapath and its issue stage.
// Opcode and register-address encodings, and the 12-bit instruction word
// layout {op[11:10], addr[9:8], data[7:0]}.
package alu_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [1:0] ADDR_X = 2'd0;
  localparam logic [1:0] ADDR_Y = 2'd1;
  localparam logic [1:0] ADDR_A = 2'd2;
  localparam logic [1:0] ADDR_B = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] data;
  } instr_t;

  // All-zero word: OP_NOP, ADDR_X, DATA=0. Driven whenever nothing issues.
  localparam instr_t INSTR_NOP = '0;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, wdata      write wdata at the tail (ignored when full)
//   pop              remove the head (ignored when empty)
//   flush            discard all contents; overrides push and pop
//   rdata            current head word (valid when !empty)
//   level            occupancy 0..DEPTH
//   full, empty      derived from level
module instr_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  instr_t           wdata,
  output instr_t           rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  instr_t             mem_q [DEPTH];
  instr_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               do_push;
  logic               do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INSTR_NOP;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/instr_issue.sv
// Instruction buffer and issue stage feeding the two-register ALU datapath.
// Host words enter a FIFO through IN_VALID/IN_READY; at most one word per
// clock is registered onto OP/ADDR/DATA, otherwise an all-zero NOP.
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   IN_VALID, IN_WORD  host word {op, addr, data}
//   IN_READY           FIFO can accept (low while full or in reset)
//   HOLD               stall issue, FIFO keeps its contents
//   FLUSH              synchronous discard; beats HOLD and push
//   OP, ADDR, DATA     registered instruction to the datapath
//   ISSUED             high while OP/ADDR/DATA carry a popped word
//   LEVEL              FIFO occupancy
//   ISSUE_CNT          saturating issue count (only with ISSUE_CNT_EN)
// Build option: define ISSUE_CNT_EN to add CNT_W and ISSUE_CNT.
//
// Handshake: a word transfers on a rising edge where IN_VALID && IN_READY.
// IN_READY depends only on the registered full flag, never on IN_VALID,
// HOLD or a same-cycle pop; the host keeps IN_WORD stable until it transfers.
module instr_issue
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
`ifdef ISSUE_CNT_EN
  parameter  int CNT_W = 16,
`endif
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  input  logic [11:0]      IN_WORD,
  output logic             IN_READY,
  input  logic             HOLD,
  input  logic             FLUSH,
  output logic [1:0]       OP,
  output logic [1:0]       ADDR,
  output logic [7:0]       DATA,
  output logic             ISSUED,
`ifdef ISSUE_CNT_EN
  output logic [CNT_W-1:0] ISSUE_CNT,
`endif
  output logic [LVL_W-1:0] LEVEL
);

  // Issue-control states; the state register itself drives ISSUED.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic       state_q, state_d;
  instr_t     out_q, out_d;
  instr_t     head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  // Ready is forced low while reset is applied.
  assign IN_READY = RST_N && !fifo_full;
  assign pop      = !HOLD && !FLUSH && !fifo_empty;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (IN_VALID && IN_READY),
    .pop   (pop),
    .flush (FLUSH),
    .wdata (instr_t'(IN_WORD)),
    .rdata (head),
    .level (LEVEL),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Every cycle either carries a fresh popped word or a NOP, so no word is
  // ever presented twice.
  always_comb begin
    state_d = ST_IDLE;
    out_d   = INSTR_NOP;
    if (pop) begin
      state_d = ST_ISSUE;
      out_d   = head;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      out_q   <= INSTR_NOP;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign OP     = out_q.op;
  assign ADDR   = out_q.addr;
  assign DATA   = out_q.data;
  assign ISSUED = (state_q == ST_ISSUE);

`ifdef ISSUE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (FLUSH) begin
      cnt_d = '0;
    end else if (pop && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ISSUE_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_instr_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef ISSUE_CNT_EN
  localparam int CNT_W = 4;
`endif
  localparam int CNT_MAX = 15;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [11:0]      in_word = '0;
  logic             hold = 1'b0;
  logic             flush = 1'b0;
  logic             in_ready;
  logic [1:0]       op;
  logic [1:0]       addr;
  logic [7:0]       data;
  logic             issued;
  logic [LVL_W-1:0] level;
`ifdef ISSUE_CNT_EN
  logic [CNT_W-1:0] issue_cnt;
`endif

  always #5 clk = ~clk;

  instr_issue #(
    .DEPTH(DEPTH)
`ifdef ISSUE_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .IN_VALID (in_valid),
    .IN_WORD  (in_word),
    .IN_READY (in_ready),
    .HOLD     (hold),
    .FLUSH    (flush),
    .OP       (op),
    .ADDR     (addr),
    .DATA     (data),
    .ISSUED   (issued),
`ifdef ISSUE_CNT_EN
    .ISSUE_CNT(issue_cnt),
`endif
    .LEVEL    (level)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buffer contents as a plain queue; each edge: flush empties it, otherwise
  // the front leaves (unless held) and an accepted word joins the back.
  logic [11:0] mdl_q[$];
  logic [11:0] exp_q[$];
  logic        exp_issued = 1'b0;
  int          exp_level = 0;
  int          exp_cnt = 0;
  logic [11:0] mdl_w;
  bit          mdl_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_q.delete();
      exp_q.delete();
      exp_issued = 1'b0;
      exp_level  = 0;
      exp_cnt    = 0;
    end else begin
      mdl_rdy = (mdl_q.size() < DEPTH);
      if (flush) begin
        mdl_q.delete();
        exp_issued = 1'b0;
        exp_cnt    = 0;
      end else begin
        exp_issued = !hold && (mdl_q.size() != 0);
        if (exp_issued) begin
          mdl_w = mdl_q.pop_front();
          exp_q.push_back(mdl_w);
          if (exp_cnt < CNT_MAX) exp_cnt++;
        end
        if (in_valid && mdl_rdy) mdl_q.push_back(in_word);
      end
      exp_level = mdl_q.size();
    end
  end

  // ---------------- monitor ----------------
  logic [11:0] mon_w;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("issued", 32'(issued), 32'(exp_issued));
      if (issued) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 32'(1), 32'(0));
        end else begin
          mon_w = exp_q.pop_front();
          chk("issue_word", 32'({op, addr, data}), 32'(mon_w));
        end
      end else begin
        chk("nop_word", 32'({op, addr, data}), 32'(0));
      end
      chk("level", 32'(level), 32'(exp_level));
      chk("in_ready", 32'(in_ready), 32'(exp_level < DEPTH));
`ifdef ISSUE_CNT_EN
      chk("issue_cnt", 32'(issue_cnt), 32'(exp_cnt));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a word and hold it until the edge that accepts it.
  task automatic push_word(input logic [11:0] w);
    int n;
    in_valid = 1'b1;
    in_word  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("push_timeout", 32'(1), 32'(0));
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    hold     = 1'b0;
    flush    = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic [11:0] mk(input logic [1:0] o, input logic [1:0] a, input logic [7:0] d);
    return {o, a, d};
  endfunction

  // ---------------- stimulus ----------------
  bit will_accept;

  initial begin
    // Power-on reset, released between edges.
    #12;
    chk("rst_word", 32'({op, addr, data}), 32'(0));
    chk("rst_issued", 32'(issued), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(0));
    #5 rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(in_ready), 32'(1));

    // Single word into an empty FIFO.
    push_word(mk(OP_LOAD, ADDR_X, 8'h05));
    idle(3);

    // Fill under HOLD, fifth word held off, then release.
    hold = 1'b1;
    push_word(mk(OP_ADD,  ADDR_Y, 8'h11));
    push_word(mk(OP_SUB,  ADDR_A, 8'h22));
    push_word(mk(OP_LOAD, ADDR_B, 8'h33));
    push_word(mk(OP_ADD,  ADDR_X, 8'h44));
    in_valid = 1'b1;
    in_word  = mk(OP_SUB, ADDR_Y, 8'h55);
    step();
    step();
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_ready", 32'(in_ready), 32'(0));
    hold = 1'b0;
    push_word(mk(OP_SUB, ADDR_Y, 8'h55));
    idle(DEPTH + 2);

    // FLUSH at LEVEL=3 together with a push.
    hold = 1'b1;
    push_word(mk(OP_ADD,  ADDR_A, 8'h61));
    push_word(mk(OP_ADD,  ADDR_A, 8'h62));
    push_word(mk(OP_ADD,  ADDR_A, 8'h63));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_word  = mk(OP_LOAD, ADDR_B, 8'h64);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_level", 32'(level), 32'(0));
    idle(3);

    // Asynchronous reset mid-stream.
    hold = 1'b1;
    push_word(mk(OP_LOAD, ADDR_X, 8'h71));
    push_word(mk(OP_LOAD, ADDR_Y, 8'h72));
    hold = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_word", 32'({op, addr, data}), 32'(0));
    chk("mid_rst_issued", 32'(issued), 32'(0));
    chk("mid_rst_level", 32'(level), 32'(0));
    #3 rst_n = 1'b1;
    step();
    push_word(mk(OP_SUB, ADDR_B, 8'h81));
    push_word(mk(OP_ADD, ADDR_A, 8'h82));
    idle(3);

    // Twenty issues (saturates a 4-bit counter), then FLUSH.
    for (int i = 0; i < 20; i++) push_word(mk(OP_ADD, ADDR_X, 8'(i)));
    idle(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle(2);

    // Random traffic; a word is only replaced once accepted.
    in_valid = 1'b1;
    in_word  = 12'($urandom);
    for (int c = 0; c < 400; c++) begin
      hold  = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 31) == 0);
      will_accept = in_valid && in_ready;
      step();
      if (will_accept || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_word  = 12'($urandom);
      end
    end

    // Drain and confirm every predicted issue was seen.
    idle(DEPTH + 3);
    @(negedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction buffer and issue stage that sits directly upstream of the two-register ALU datapath. A host pushes 12-bit instruction words {OP, ADDR, DATA} through a valid/ready handshake into a small FIFO. The block issues at most one instruction per clock onto the datapath's OP/ADDR/DATA inputs and drives NOP (OP=00) whenever nothing is issuable. All flops are posedge CLK, so issue outputs are stable a half cycle before the datapath's negedge sample.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of the issued-instruction counter.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  host word valid.
- IN_WORD  in  12  host word; [11:10]=OP, [9:8]=ADDR, [7:0]=DATA.
- IN_READY  out  1  FIFO can accept; equals !full.
- HOLD  in  1  stall issue; the FIFO keeps its contents.
- FLUSH  in  1  synchronous discard of all buffered words.
- OP  out  2  to datapath OP.
- ADDR  out  2  to datapath ADDR.
- DATA  out  8  to datapath DATA.
- ISSUED  out  1  high for the cycle in which OP/ADDR/DATA carry a real popped word.
- LEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: on a rising edge with IN_VALID && IN_READY, IN_WORD is written at the tail. No push when full; the host holds the word until IN_READY is high.
- Pop/issue: on a rising edge with !HOLD && !FLUSH && !empty, the head is registered onto OP/ADDR/DATA with ISSUED=1, and the head is removed.
- Otherwise on a rising edge: OP/ADDR/DATA are registered to 0 (NOP, ADDR=00, DATA=00) and ISSUED=0. An instruction is never presented for more than one cycle.
- Simultaneous push and pop: both take effect and LEVEL is unchanged. IN_READY depends only on the registered full flag; there is no same-cycle bypass.
- Empty: no bypass, so a word written into an empty FIFO issues no earlier than the following edge.
- FLUSH: at the edge it is sampled, LEVEL becomes 0, the pointers reset, a push in that same cycle is dropped, and outputs are NOP. FLUSH has priority over HOLD and over push.
- Issue-control state machine:
  - IDLE: empty, or HOLD asserted.
  - ISSUE: a pop occurred this cycle.
  - Transition: ISSUE is entered whenever a pop occurs; any cycle without a pop returns to IDLE.
  - The state is visible as ISSUED.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. full/empty come from LEVEL (0 or DEPTH).
- Reset (RST_N low, async):
  - OP=0, ADDR=0, DATA=0, ISSUED=0.
  - LEVEL=0, IN_READY=1 once RST_N is released (it reads 0 while in reset), pointers=0, counter=0.
  - Reset mid-stream discards all buffered words.

## Timing
- Latency: a word accepted at edge k appears on OP/ADDR/DATA after edge k+1 when the FIFO was empty and HOLD=0.
- Throughput: one word per cycle sustained.
- HOLD released at edge k: the head issues after edge k (HOLD is sampled at that edge).
- The datapath samples on the falling edge between issue edges, giving half a cycle of setup.

## Configuration
- ISSUE_CNT_EN defined:
  - Adds output ISSUE_CNT [CNT_W-1:0], which increments on every issue.
  - It saturates at all-ones and does not wrap.
  - It is cleared by reset and by FLUSH.
- ISSUE_CNT_EN undefined: neither the port nor the counter exists, and behaviour is otherwise identical.

## Structure
- Shared package alu_pkg:
  - Opcode constants OP_NOP=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_LOAD=2'b11.
  - Address constants ADDR_X=0, ADDR_Y=1, ADDR_A=2, ADDR_B=3.
  - Packed instr_t {op, addr, data}.
- One sub-module, instr_fifo: synchronous FIFO with push/pop/flush, level, full and empty. instr_issue owns the output register and the state machine.

## Test plan
- Reset then push {OP_LOAD, ADDR_X, 8'h05} into an empty FIFO:
  - ISSUED=1 with OP=11, ADDR=00, DATA=05 exactly one edge later.
  - NOP (all zeros, ISSUED=0) on the following cycle.
- Four back-to-back pushes with HOLD=1 (DEPTH=4):
  - LEVEL=4 and IN_READY=0; a fifth word is held off.
  - Drop HOLD: the four words issue on four consecutive cycles in order.
- Full FIFO with IN_VALID=1 and pop in the same cycle:
  - LEVEL stays at DEPTH-1 after the pop.
  - The held fifth word is accepted on the next edge once IN_READY rises.
- FLUSH asserted at LEVEL=3 together with a push: LEVEL=0, NOP outputs, and the pushed word never issues.
- RST_N pulsed low mid-stream, asynchronously between edges:
  - Outputs go to 0 immediately and LEVEL=0.
  - Post-reset pushes issue normally.
- With ISSUE_CNT_EN and CNT_W=4: 20 issues leave ISSUE_CNT=4'hF (saturated), and FLUSH clears it to 0.
